ifu_idu_queue: RTL and testbench
================================

Name: ifu_idu_queue

Overview:
- Decoupling instruction queue between the fetch unit (upstream) and the decode unit (downstream).
- Buffers fetched {pc, instr} pairs in a small circular FIFO with valid/ready handshakes on both sides.
- Flushed in one cycle on a control-flow redirect.
- Lets fetch continue while decode stalls, and isolates decode from pmem read timing.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PC_W, 64, program-counter width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  redirect from execute; discard all queued and incoming entries.
- in_valid  in  1  fetch presents a valid {in_pc, in_instr}.
- in_pc  in  PC_W  pc of fetched instruction.
- in_instr  in  INST_W  fetched instruction word.
- in_ready  out  1  queue can accept this cycle.
- out_valid  out  1  head entry valid for decode.
- out_pc  out  PC_W  head pc.
- out_instr  out  INST_W  head instruction.
- out_ready  in  1  decode consumes head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage and state:
  - DEPTH-entry array of {pc, instr}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate register.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, array cleared to 0; out_valid=0, in_ready=1, count=0.
- Handshake signals:
  - in_ready = (count != DEPTH). Registered-state only; no combinational path from out_ready.
  - out_valid = (count != 0) && !flush.
- Transfers:
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready.
- Outputs:
  - out_pc/out_instr = head entry when out_valid=1.
  - Otherwise out_pc=0 and out_instr=32'h00000013 (NOP), so the decoder never sees stale data.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 (without the optional feature).
- Simultaneous push and pop:
  - Allowed whenever count is 1..DEPTH-1; count unchanged, both pointers advance.
  - When full, in_ready=0, so no push even if pop occurs (no pass-through when full).
  - When empty, pop is impossible.
- Flush:
  - Highest priority. At the next edge wr_ptr=rd_ptr=0 and count=0.
  - A push attempted in the flush cycle is dropped. The fetch side must redirect pc itself.
  - out_valid is forced low in the flush cycle, so no pop occurs.
  - flush held for multiple cycles keeps the queue empty.
- Reset mid-operation: all entries lost immediately; outputs go to reset values asynchronously.
- Arithmetic:
  - Pointer increment is plain +1 truncated to pointer width (natural wrap).
  - count is updated +1 on push-only, -1 on pop-only, and held otherwise.
  - count is never observed outside 0..DEPTH; the assertion fires on violation.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count==0 and !flush, out_valid = in_valid, and out_pc/out_instr = in_pc/in_instr combinationally.
  - If out_ready is also 1, the entry is consumed the same cycle and not written; count stays 0 and pointers are unchanged.
  - If out_ready=0, the entry is written normally.
  - Zero-cycle latency when empty.
- Undefined: strict one-cycle latency; no combinational in_*->out_* path.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h00000013.
  - RESET_PC = 64'h80000000.
  - A typedef fetch_entry_t = {pc[63:0], instr[31:0]}.
- One natural sub-module: ifu_idu_queue_mem, a DEPTH x (PC_W+INST_W) register array with one write port, one async read port and async clear. Pointers, count and handshake logic stay in the top.

Test Plan:
- Reset, then push 4 entries (pc 0x80000000..0x8000000C, instr 0x00100093+k) with out_ready=0 -> count=4, in_ready=0 after the 4th; a 5th in_valid is not accepted.
- Drain with out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008, 0x8000000C in order; then out_valid=0, out_instr=0x00000013, out_pc=0.
- Continuous push+pop at count=2 for 20 cycles with pc incrementing by 4 -> count stays 2; ptrs wrap past 3 with FIFO order preserved.
- Count=3, assert flush with in_valid=1 and pc 0x80000100 -> out_valid=0 that cycle; next cycle count=0 and the 0x80000100 entry is absent.
- Assert rst asynchronously (between edges) with count=2 -> out_valid=0, count=0, in_ready=1 before the next edge.
- IFQ_BYPASS_EN defined, empty, in_valid=1, out_ready=1, in_pc=0x80000040 -> same cycle out_valid=1, out_pc=0x80000040; count remains 0. Undefined: out_valid=0 that cycle, 1 the next.

Source files
------------

// File: rtl/ifu_idu_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
// Holds the NOP filler, the reset pc and the {pc, instr} entry type.
package ifu_idu_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [63:0] RESET_PC  = 64'h80000000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_idu_queue_mem.sv
// Queue storage: DEPTH x W register array.
// One write port, one async read port, async clear on rst.
module ifu_idu_queue_mem
    import ifu_idu_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 96,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write one entry per cycle; the whole array clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifu_idu_queue.sv
// Decoupling instruction queue between fetch and decode.
// IFQ_BYPASS_EN: forward fetch straight to decode when the queue is empty.
module ifu_idu_queue
    import ifu_idu_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_instr,
    input  logic              out_ready,
    output logic [CW-1:0]     count
);

    localparam int W = PC_W + INST_W;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [W-1:0]  rdata;
    logic          empty;
    logic          head_valid;
    logic          push;
    logic          pop;

    assign empty      = (count == '0);
    assign head_valid = !empty && !flush;
    assign in_ready   = (count != CW'(DEPTH));
    assign pop        = head_valid && out_ready;

`ifdef IFQ_BYPASS_EN
    logic byp;
    logic byp_take;

    assign byp      = empty && !flush && in_valid;
    assign byp_take = byp && out_ready;
    assign push     = in_valid && in_ready && !flush && !byp_take;

    // Head entry, or the incoming fetch when the queue is empty.
    always_comb begin
        out_valid = head_valid || byp;
        out_pc    = '0;
        out_instr = INST_W'(NOP_INSTR);
        if (byp) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (head_valid) begin
            out_pc    = rdata[W-1:INST_W];
            out_instr = rdata[INST_W-1:0];
        end
    end
`else
    assign push = in_valid && in_ready && !flush;

    // Head entry, or pc 0 / NOP so decode never sees stale data.
    always_comb begin
        out_valid = head_valid;
        out_pc    = '0;
        out_instr = INST_W'(NOP_INSTR);
        if (head_valid) begin
            out_pc    = rdata[W-1:INST_W];
            out_instr = rdata[INST_W-1:0];
        end
    end
`endif

    // Pointers and occupancy; flush wins over any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    ifu_idu_queue_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    count_range_a: assert property (
        @(posedge clk) disable iff (rst) count <= CW'(DEPTH)
    );

endmodule

// File: tb/tb_ifu_idu_queue.sv
// Directed self-checking bench for ifu_idu_queue.
// Covers fill, drain, wrap, flush, async reset and empty latency.
module tb_ifu_idu_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int total;
    int bad;

    ifu_idu_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] base;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'h13);
        chk("rst_out_pc", out_pc, 64'd0);
        step();
        rst = 1'b0;
        step();

        // fill to full with decode stalled
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_pc    = 64'h80000000 + 64'(4 * k);
            in_instr = 32'h00100093 + 32'(k);
            step();
        end
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_head_pc", out_pc, 64'h80000000);
        in_pc    = 64'h80000010;
        in_instr = 32'h00100097;
        step();
        chk("full_no_push", 64'(count), 64'd4);
        in_valid = 1'b0;

        // drain in order
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_pc", out_pc, 64'h80000000 + 64'(4 * k));
            chk("drain_instr", 64'(out_instr), 64'(32'h00100093 + 32'(k)));
            step();
        end
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_instr", 64'(out_instr), 64'h13);
        chk("empty_pc", out_pc, 64'd0);
        chk("empty_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // prime two entries, then stream push+pop for 20 cycles
        base = 64'h80000200;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_pc    = base + 64'(4 * k);
            in_instr = 32'(k);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_pc    = base + 64'(4 * (i + 2));
            in_instr = 32'(i + 2);
            chk("stream_pc", out_pc, base + 64'(4 * i));
            chk("stream_instr", 64'(out_instr), 64'(i));
            chk("stream_count", 64'(count), 64'd2);
            step();
        end
        chk("stream_end_count", 64'(count), 64'd2);
        chk("stream_end_pc", out_pc, base + 64'(80));

        // go to count 3, then flush with a push attempt
        out_ready = 1'b0;
        in_pc     = base + 64'(88);
        step();
        chk("pre_flush_count", 64'(count), 64'd3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 64'h80000100;
        out_ready = 1'b1;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("post_flush_count", 64'(count), 64'd0);
        chk("post_flush_valid", 64'(out_valid), 64'd0);
        chk("post_flush_pc", out_pc, 64'd0);
        step();
        chk("flush_drop_count", 64'(count), 64'd0);

        // two entries then async reset between edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_pc = 64'h80000300 + 64'(4 * k);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        step();

        // empty-queue latency
        in_valid  = 1'b1;
        in_pc     = 64'h80000040;
        in_instr  = 32'h00000093;
        out_ready = 1'b1;
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_valid", 64'(out_valid), 64'd1);
        chk("byp_pc", out_pc, 64'h80000040);
        step();
        in_valid = 1'b0;
        chk("byp_count", 64'(count), 64'd0);
        chk("byp_after_valid", 64'(out_valid), 64'd0);
`else
        chk("lat_same_valid", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        chk("lat_next_valid", 64'(out_valid), 64'd1);
        chk("lat_next_pc", out_pc, 64'h80000040);
        step();
        chk("lat_drained", 64'(count), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
